inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Responder end of the core's instruction-fetch interface.
- Accepts the fetch request (chip-enable plus word address) from the pipeline's PC stage and returns the 32-bit instruction.
- Instructions come from a direct-mapped, one-word-per-line cache. On a miss, it refills from a byte-wide external memory with fixed 1-cycle read latency.
- Raises a stall toward the pipeline while a refill is in progress. Sits between the core top and the system memory bus.

Parameters:
- INDEX_W, 6, log2 of line count (64 lines). Index = rom_addr_i[INDEX_W+1:2]; tag = rom_addr_i[31:INDEX_W+2].

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- rom_ce_i  input  1  fetch request enable from PC stage
- rom_addr_i  input  32  fetch byte address; bits [1:0] ignored
- rom_data_o  output  32  instruction word, valid when rom_valid_o=1
- rom_valid_o  output  1  hit this cycle; rom_data_o is good
- stall_o  output  1  pipeline must hold PC/IF-ID
- flush_i  input  1  invalidate all lines (fence.i)
- mem_a_o  output  32  external byte read address
- mem_rd_o  output  1  external read strobe
- mem_din_i  input  8  external read data, valid the cycle after the mem_rd_o/mem_a_o cycle

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, all valid bits=0, cnt=0, latched address=0. Outputs after the reset edge: rom_data_o=0, rom_valid_o=0, stall_o=0, mem_rd_o=0, mem_a_o=0. Tag/data arrays need not be cleared.
- Hit is combinational in IDLE: rom_ce_i=1 and valid[idx]=1 and tag[idx]==tag(rom_addr_i).
  - On a hit: rom_valid_o=1, rom_data_o=data[idx], stall_o=0, same cycle.
- rom_ce_i=0 in IDLE: rom_valid_o=0, rom_data_o=0, stall_o=0, no state change.
- Miss in IDLE (ce=1, no hit): stall_o=1 combinationally. On the edge, latch word address base={rom_addr_i[31:2],2'b00}, set cnt=0, and go to FETCH.
- FETCH, per cycle with counter cnt in 0..4:
  - cnt<4: mem_rd_o=1, mem_a_o=base+cnt.
  - cnt>=1: capture mem_din_i into byte lane cnt-1 (little-endian: byte 0 -> bits[7:0]).
  - cnt 0..3: cnt increments.
  - cnt=4: mem_rd_o=0. On the edge, write the assembled word, the tag, and valid=1 into line idx(base), then return to IDLE.
  - stall_o=1, rom_valid_o=0 and rom_data_o=0 throughout FETCH.
- Miss timing: miss seen at cycle t0; FETCH occupies t1..t5; first possible hit at t6. Stall therefore spans 6 cycles (t0..t5).
- Outside FETCH: mem_rd_o=0, mem_a_o holds its last value.
- Address change or rom_ce_i drop during FETCH: ignored. The refill completes for the latched base, and the lookup is re-evaluated in IDLE.
- flush_i=1 (any state): on the edge, clear all valid bits. If in FETCH, abort to IDLE and do not write the line. The same-cycle IDLE hit check still uses the pre-flush valid bits.
- Flush with a simultaneous miss in IDLE: flush wins; stay in IDLE and re-miss next cycle.
- Reset mid-FETCH: return to IDLE at the edge with all lines invalid. No partial line write; mem_rd_o=0 from the next cycle.
- Aliasing: addresses with an equal index and a different tag evict each other; only one is resident at a time.
- Address wrap: base+cnt is computed in 32 bits. With base=32'hFFFFFFFC, the byte addresses issued are FFFFFFFC..FFFFFFFF; there is no carry into tag logic because base is word-aligned.

Test Plan:
- Cold miss: reset, then ce=1, addr=0x00000000; memory bytes 0x13,0x05,0x10,0x00.
  -> stall_o=1 for 6 cycles; mem_a_o sequence 0,1,2,3.
  -> Cycle 7: rom_valid_o=1, rom_data_o=0x00100513.
- Repeat hit: same address again -> rom_valid_o=1 same cycle, stall_o=0, mem_rd_o stays 0.
- Conflict eviction (INDEX_W=6): fill 0x00000004, then fetch 0x00000104 (same index 1).
  -> Miss with 6-cycle stall.
  -> Refetching 0x00000004 misses again.
- Flush: line 0x00000000 resident; pulse flush_i for 1 cycle.
  -> Next fetch of 0x00000000 misses; stall_o=1 for 6 cycles.
- Reset mid-refill: assert rst at FETCH cnt=2.
  -> Next cycle mem_rd_o=0, stall_o=0 (ce=0).
  -> Subsequent fetch of that address misses and refills fully.
- Address wiggle during refill: miss on 0x00000010; change rom_addr_i to 0x00000020 at cnt=1.
  -> Line for 0x10 filled.
  -> IDLE then misses on 0x20 and starts a new 6-cycle refill with mem_a_o 0x20..0x23.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache that refills a missing
// word byte by byte from an external memory with a fixed 1-cycle read latency.
module inst_cache #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        rom_valid_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic [31:0] mem_a_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_din_i
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 32 - INDEX_W - 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       mem_a_q, mem_a_d;
    logic [23:0]       buf_q, buf_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [INDEX_W-1:0] req_idx_s;
    logic [INDEX_W-1:0] base_idx_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic [TAG_W-1:0]   base_tag_s;
    logic               hit_s;
    logic               line_we_s;
    logic [31:0]        line_word_s;
    logic               unused_s;

    assign req_idx_s   = rom_addr_i[INDEX_W+1:2];
    assign req_tag_s   = rom_addr_i[31:INDEX_W+2];
    assign base_idx_s  = base_q[INDEX_W+1:2];
    assign base_tag_s  = base_q[31:INDEX_W+2];
    assign unused_s    = ^rom_addr_i[1:0];
    // The last byte arrives in the same cycle the line is written.
    assign line_word_s = {mem_din_i, buf_q};

    assign hit_s = (state_q == IDLE) && rom_ce_i && valid_q[req_idx_s]
                   && (tag_q[req_idx_s] == req_tag_s);

    // Lookup, refill sequencing and next-state computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        buf_d       = buf_q;
        valid_d     = valid_q;
        mem_a_d     = mem_a_q;
        mem_a_o     = mem_a_q;
        mem_rd_o    = 1'b0;
        rom_valid_o = 1'b0;
        rom_data_o  = 32'h0000_0000;
        stall_o     = 1'b0;
        line_we_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rom_ce_i) begin
                    if (hit_s) begin
                        rom_valid_o = 1'b1;
                        rom_data_o  = data_q[req_idx_s];
                    end else begin
                        stall_o = 1'b1;
                        state_d = FETCH;
                        cnt_d   = 3'd0;
                        base_d  = {rom_addr_i[31:2], 2'b00};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                stall_o = 1'b1;
                if (cnt_q < 3'd4) begin
                    mem_rd_o = 1'b1;
                    mem_a_o  = base_q + {29'd0, cnt_q};
                    mem_a_d  = base_q + {29'd0, cnt_q};
                end else begin
                    mem_rd_o = 1'b0;
                end
                // Byte read in cycle cnt-1 is on mem_din_i now.
                case (cnt_q)
                    3'd1:    buf_d[7:0]   = mem_din_i;
                    3'd2:    buf_d[15:8]  = mem_din_i;
                    3'd3:    buf_d[23:16] = mem_din_i;
                    default: buf_d        = buf_q;
                endcase
                if (cnt_q == 3'd4) begin
                    line_we_s           = 1'b1;
                    valid_d[base_idx_s] = 1'b1;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush beats both a pending miss and a completing refill.
        if (flush_i) begin
            valid_d   = {LINES{1'b0}};
            state_d   = IDLE;
            line_we_s = 1'b0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            base_q  <= 32'h0000_0000;
            mem_a_q <= 32'h0000_0000;
            buf_q   <= 24'h00_0000;
            valid_q <= {LINES{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            mem_a_q <= mem_a_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays; contents are qualified by valid_q so need no reset.
    always_ff @(posedge clk) begin
        if (line_we_s && !rst) begin
            tag_q[base_idx_s]  <= base_tag_s;
            data_q[base_idx_s] <= line_word_s;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with a byte-wide memory model.
module tb_inst_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        rom_valid_o;
    logic        stall_o;
    logic        flush_i;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic [7:0]  mem_din_i;

    int checks = 0;
    int passed = 0;

    logic [7:0]  arr [0:511];
    int          r_stalls;
    int          r_nrd;
    logic        r_valid;
    logic        r_clean;
    logic [31:0] r_data;
    logic [31:0] r_a [0:15];

    inst_cache #(.INDEX_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .rom_valid_o (rom_valid_o),
        .stall_o     (stall_o),
        .flush_i     (flush_i),
        .mem_a_o     (mem_a_o),
        .mem_rd_o    (mem_rd_o),
        .mem_din_i   (mem_din_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a < 32'd512) return arr[a[8:0]];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // External memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_o) mem_din_i <= mem_byte(mem_a_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect();
        r_stalls = 0; r_nrd = 0; r_valid = 1'b0; r_clean = 1'b0; r_data = 32'h0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rom_valid_o) begin
                r_valid = 1'b1;
                r_data  = rom_data_o;
                r_clean = !stall_o && !mem_rd_o;
                break;
            end
            if (stall_o) r_stalls++;
            if (mem_rd_o) begin
                if (r_nrd < 16) r_a[r_nrd] = mem_a_o;
                r_nrd++;
            end
            step();
        end
        step();
        rom_ce_i = 1'b0;
    endtask

    task automatic run_fetch(input logic [31:0] a);
        rom_ce_i   = 1'b1;
        rom_addr_i = a;
        collect();
    endtask

    task automatic test_reset();
        rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'h0; flush_i = 1'b0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rom_data_o, rom_valid_o, stall_o, mem_rd_o, mem_a_o} !== 67'h0)
            $display("FAIL reset_outputs: got data=%h v=%b st=%b rd=%b a=%h expected all zero",
                     rom_data_o, rom_valid_o, stall_o, mem_rd_o, mem_a_o);
        else passed++;
        step();
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h0000_0000);
        checks++;
        if (r_stalls !== 6) $display("FAIL cold_stall: got %0d expected 6", r_stalls); else passed++;
        checks++;
        if (r_nrd !== 4 || r_a[0] !== 32'h0 || r_a[1] !== 32'h1 || r_a[2] !== 32'h2 || r_a[3] !== 32'h3)
            $display("FAIL cold_addr_seq: got n=%0d %h %h %h %h expected 4 0 1 2 3",
                     r_nrd, r_a[0], r_a[1], r_a[2], r_a[3]);
        else passed++;
        checks++;
        if (r_valid !== 1'b1 || r_data !== 32'h0010_0513)
            $display("FAIL cold_data: got v=%b %h expected 1 00100513", r_valid, r_data);
        else passed++;
    endtask

    task automatic test_repeat_hit();
        run_fetch(32'h0000_0000);
        checks++;
        if (r_stalls !== 0 || r_nrd !== 0 || r_clean !== 1'b1)
            $display("FAIL hit_nostall: got stalls=%0d reads=%0d clean=%b expected 0 0 1",
                     r_stalls, r_nrd, r_clean);
        else passed++;
        checks++;
        if (r_data !== 32'h0010_0513) $display("FAIL hit_data: got %h expected 00100513", r_data);
        else passed++;
    endtask

    task automatic test_conflict();
        run_fetch(32'h0000_0004);
        checks++;
        if (r_data !== word_at(32'h4)) $display("FAIL fill_04: got %h expected %h", r_data, word_at(32'h4));
        else passed++;
        run_fetch(32'h0000_0104);
        checks++;
        if (r_stalls !== 6 || r_data !== word_at(32'h104) || r_a[0] !== 32'h104)
            $display("FAIL evict_104: got st=%0d %h a0=%h expected 6 %h 104",
                     r_stalls, r_data, r_a[0], word_at(32'h104));
        else passed++;
        run_fetch(32'h0000_0004);
        checks++;
        if (r_stalls !== 6 || r_data !== word_at(32'h4))
            $display("FAIL refetch_04: got st=%0d %h expected 6 %h", r_stalls, r_data, word_at(32'h4));
        else passed++;
    endtask

    task automatic test_flush();
        rom_ce_i = 1'b1; rom_addr_i = 32'h0; flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (rom_valid_o !== 1'b1 || rom_data_o !== 32'h0010_0513)
            $display("FAIL flush_same_cycle_hit: got v=%b %h expected 1 00100513", rom_valid_o, rom_data_o);
        else passed++;
        step();
        flush_i = 1'b0;
        run_fetch(32'h0000_0000);
        checks++;
        if (r_stalls !== 6 || r_data !== 32'h0010_0513)
            $display("FAIL flush_remiss: got st=%0d %h expected 6 00100513", r_stalls, r_data);
        else passed++;
        // Flush together with a miss: refill must not start this cycle.
        rom_ce_i = 1'b1; rom_addr_i = 32'h80; flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b1 || rom_valid_o !== 1'b0)
            $display("FAIL flush_miss_stall: got st=%b v=%b expected 1 0", stall_o, rom_valid_o);
        else passed++;
        step();
        flush_i = 1'b0;
        run_fetch(32'h0000_0080);
        checks++;
        if (r_stalls !== 6 || r_nrd !== 4 || r_a[0] !== 32'h80 || r_data !== word_at(32'h80))
            $display("FAIL flush_miss_refill: got st=%0d n=%0d a0=%h %h expected 6 4 80 %h",
                     r_stalls, r_nrd, r_a[0], r_data, word_at(32'h80));
        else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        rom_ce_i = 1'b1; rom_addr_i = 32'h40;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b1 || mem_a_o !== 32'h42)
            $display("FAIL rst_mid_cnt2: got rd=%b a=%h expected 1 00000042", mem_rd_o, mem_a_o);
        else passed++;
        rst = 1'b1; rom_ce_i = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL rst_mid_quiet: got rd=%b st=%b expected 0 0", mem_rd_o, stall_o);
        else passed++;
        step();
        run_fetch(32'h0000_0040);
        checks++;
        if (r_stalls !== 6 || r_nrd !== 4 || r_data !== word_at(32'h40))
            $display("FAIL rst_mid_refill: got st=%0d n=%0d %h expected 6 4 %h",
                     r_stalls, r_nrd, r_data, word_at(32'h40));
        else passed++;
    endtask

    task automatic test_addr_wiggle();
        rom_ce_i = 1'b1; rom_addr_i = 32'h10;
        step();
        @(negedge clk);
        checks++;
        if (mem_rd_o !== 1'b1 || mem_a_o !== 32'h10)
            $display("FAIL wiggle_first_rd: got rd=%b a=%h expected 1 00000010", mem_rd_o, mem_a_o);
        else passed++;
        step();
        rom_addr_i = 32'h20;
        collect();
        checks++;
        if (r_stalls !== 10 || r_nrd !== 7 || r_a[0] !== 32'h11 || r_a[2] !== 32'h13
            || r_a[3] !== 32'h20 || r_a[6] !== 32'h23)
            $display("FAIL wiggle_seq: got st=%0d n=%0d %h %h %h %h expected 10 7 11 13 20 23",
                     r_stalls, r_nrd, r_a[0], r_a[2], r_a[3], r_a[6]);
        else passed++;
        checks++;
        if (r_data !== word_at(32'h20)) $display("FAIL wiggle_data20: got %h expected %h", r_data, word_at(32'h20));
        else passed++;
        run_fetch(32'h0000_0010);
        checks++;
        if (r_stalls !== 0 || r_data !== word_at(32'h10))
            $display("FAIL wiggle_hit10: got st=%0d %h expected 0 %h", r_stalls, r_data, word_at(32'h10));
        else passed++;
    endtask

    task automatic test_wrap();
        run_fetch(32'hFFFF_FFFC);
        checks++;
        if (r_nrd !== 4 || r_a[0] !== 32'hFFFF_FFFC || r_a[3] !== 32'hFFFF_FFFF)
            $display("FAIL wrap_addr: got n=%0d %h %h expected 4 fffffffc ffffffff", r_nrd, r_a[0], r_a[3]);
        else passed++;
        checks++;
        if (r_data !== 32'hA5A4_A7A6) $display("FAIL wrap_data: got %h expected a5a4a7a6", r_data);
        else passed++;
        run_fetch(32'hFFFF_FFFE);
        checks++;
        if (r_stalls !== 0 || r_data !== 32'hA5A4_A7A6)
            $display("FAIL wrap_hit: got st=%0d %h expected 0 a5a4a7a6", r_stalls, r_data);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) arr[i] = 8'((i * 7 + 3) & 255);
        arr[0] = 8'h13; arr[1] = 8'h05; arr[2] = 8'h10; arr[3] = 8'h00;
        mem_din_i = 8'h00;
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_conflict();
        test_flush();
        test_reset_mid_fetch();
        test_addr_wiggle();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
